bridge_xfer_sched: RTL and testbench
====================================

// Module: bridge_xfer_sched
// PURPOSE
//  Burst scheduler between the AXI reader/writer front-ends and the single APB engine.
//  Arbitrates read and write address requests round-robin and unrolls each AXI burst into single APB beats.
//  Beat addresses follow FIXED/INCR/WRAP rules. Each burst ends with one summary response to the requester that issued it.
// PARAMETERS
//  ADDR_WIDTH      32  address width
//  DATA_WIDTH      32  APB data width; bus bytes NB = DATA_WIDTH/8
//  LEN_WIDTH       8   AXI length field width (beats = len+1)
//  ID_WIDTH        4   transaction ID width
//  TIMEOUT_CYCLES  256 watchdog limit per beat (used only with macro)
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous active-low reset
//  rd_req_valid   in   1           read request pending
//  rd_req_ready   out  1           read request accepted
//  rd_req_addr    in   ADDR_WIDTH  start address
//  rd_req_len     in   LEN_WIDTH   beats-1
//  rd_req_size    in   3           log2 bytes per beat
//  rd_req_burst   in   2           0 FIXED, 1 INCR, 2 WRAP
//  rd_req_id      in   ID_WIDTH    transaction ID
//  wr_req_*       in/out           same set as rd_req_* for writes
//  beat_valid     out  1           beat presented to APB engine
//  beat_addr      out  ADDR_WIDTH  beat address
//  beat_write     out  1           1 write, 0 read
//  beat_last      out  1           final beat of burst
//  beat_id        out  ID_WIDTH    owning ID
//  beat_done      in   1           engine finished current beat (1-cycle pulse)
//  beat_err       in   1           PSLVERR of that beat, valid with beat_done
//  resp_valid     out  1           burst summary response
//  resp_ready     in   1           response consumed
//  resp_write     out  1           response belongs to write side
//  resp_id        out  ID_WIDTH    ID of finished burst
//  resp_err       out  1           1 = SLVERR
//  timeout        out  1           1-cycle pulse on beat abort (macro only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, state IDLE, last_grant=write so the first tie goes to read.
//  - FSM:
//    - IDLE: grant one side. If both valid, serve the side not served last. That side's req_ready=1 (combinational, only in IDLE).
//      Capture on valid&&ready, go to BEAT. beat_valid rises the next cycle.
//    - BEAT: beat_valid=1, outputs stable until beat_done.
//      On beat_done: OR beat_err into sticky err. If beat_last, go to RESP; else advance address and beat_cnt.
//      The next beat_valid is asserted the cycle after beat_done with no gap; beat_valid stays high.
//    - RESP: resp_valid=1 with captured id/write/err. On resp_ready, go to IDLE.
//      No request is accepted in the same cycle; the earliest new accept is the next cycle.
//  - beat_last = (beat_cnt == captured len). beat_cnt width is LEN_WIDTH.
//  - Address, with B = 1<<size:
//    - FIXED: beat_addr constant.
//    - INCR: beat 0 = start addr; then aligned(addr,B)+B per beat. Wraps modulo 2^ADDR_WIDTH; no 4KB check.
//    - WRAP: container = (len+1)*B, aligned down. Increment by B; on reaching container top, return to container base.
//  - Illegal requests: size > log2(NB), WRAP with len not in {1,3,7,15}, or burst=3.
//    - Accepted, no beats issued, go directly to RESP with resp_err=1.
//  - beat_done outside BEAT is ignored. resp_ready outside RESP is ignored.
//  - A request that deasserts valid before ready is simply not captured; the arbiter re-evaluates every IDLE cycle.
// CONFIGURATION
//  BRIDGE_SCHED_TIMEOUT_EN defined:
//   - A watchdog counts cycles in BEAT since the last beat_done or beat entry.
//   - When the count reaches TIMEOUT_CYCLES with no beat_done: pulse timeout, drop beat_valid, skip remaining beats, go to RESP with resp_err=1.
//   - A beat_done in the same cycle as expiry wins; no timeout.
//  Not defined: no counter, timeout tied 0, BEAT waits indefinitely.
// TESTING
//  - INCR read, addr 0x100, len 3, size 2 -> beat addrs 0x100,0x104,0x108,0x10C; beat_last on 4th; resp_err=0, resp_write=0.
//  - WRAP write, addr 0x10C, len 3, size 2 -> beats 0x10C,0x100,0x104,0x108; one resp, resp_write=1.
//  - rd and wr valid same cycle after reset -> read granted first, then write; alternates over 4 back-to-back pairs.
//  - INCR len 2 with beat_err=1 on beat 1 only -> all 3 beats issued, resp_err=1; size 3 on 32-bit bus -> no beats, resp_err=1.
//  - rst_n low mid-burst (beat 2 of 4) -> beat_valid/resp_valid 0 immediately; after release, new request starts cleanly at beat 0.
//  - Macro on, TIMEOUT_CYCLES=16, beat_done withheld -> timeout pulse 16 cycles after beat entry, resp_err=1, no further beats.

Source files
------------

// File: rtl/bridge_xfer_sched.sv
// bridge_xfer_sched: burst scheduler between the AXI read/write front-ends and
// the single APB engine. Arbitrates read and write requests round-robin,
// unrolls each burst into single beats (FIXED/INCR/WRAP addressing) and
// returns one summary response per burst to the requesting side.
//
// Optional feature: define BRIDGE_SCHED_TIMEOUT_EN to enable a per-beat
// watchdog (TIMEOUT_CYCLES). Without it, timeout is tied 0 and a beat waits
// indefinitely for beat_done.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rd_req_* / wr_req_*        request handshake and burst descriptor per side
//   beat_valid/addr/write/last/id   beat presented to the APB engine
//   beat_done, beat_err        engine completion pulse and its PSLVERR
//   resp_valid/ready/write/id/err   burst summary response handshake
//   timeout                    1-cycle pulse when a beat is aborted
module bridge_xfer_sched #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [LEN_WIDTH-1:0]  rd_req_len,
  input  logic [2:0]            rd_req_size,
  input  logic [1:0]            rd_req_burst,
  input  logic [ID_WIDTH-1:0]   rd_req_id,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [LEN_WIDTH-1:0]  wr_req_len,
  input  logic [2:0]            wr_req_size,
  input  logic [1:0]            wr_req_burst,
  input  logic [ID_WIDTH-1:0]   wr_req_id,
  output logic                  beat_valid,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic                  beat_write,
  output logic                  beat_last,
  output logic [ID_WIDTH-1:0]   beat_id,
  input  logic                  beat_done,
  input  logic                  beat_err,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [ID_WIDTH-1:0]   resp_id,
  output logic                  resp_err,
  output logic                  timeout
);

  localparam int unsigned NB       = DATA_WIDTH / 8;
  localparam int unsigned MAX_SIZE = (NB > 1) ? $clog2(NB) : 0;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  if (DATA_WIDTH < 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("bridge_xfer_sched: DATA_WIDTH must be >= 8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BEAT, ST_RESP} state_e;

  state_e                state_q;
  logic                  last_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  write_q;
  logic                  beat_valid_q;
  logic                  beat_last_q;
  logic                  err_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;

  // Round-robin grant: on a tie, serve the side that was not served last.
  logic grant_rd, grant_wr, accept;
  assign grant_rd     = rd_req_valid && (!wr_req_valid || last_wr_q);
  assign grant_wr     = wr_req_valid && !grant_rd;
  assign rd_req_ready = (state_q == ST_IDLE) && grant_rd;
  assign wr_req_ready = (state_q == ST_IDLE) && grant_wr;
  assign accept       = (state_q == ST_IDLE) && (grant_rd || grant_wr);

  // Descriptor of the granted side.
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [2:0]            req_size;
  logic [1:0]            req_burst;
  logic [ID_WIDTH-1:0]   req_id;
  assign req_addr  = grant_wr ? wr_req_addr  : rd_req_addr;
  assign req_len   = grant_wr ? wr_req_len   : rd_req_len;
  assign req_size  = grant_wr ? wr_req_size  : rd_req_size;
  assign req_burst = grant_wr ? wr_req_burst : rd_req_burst;
  assign req_id    = grant_wr ? wr_req_id    : rd_req_id;

  // Illegal bursts are accepted but answered with an error and no beats.
  logic wrap_len_ok, req_illegal;
  assign wrap_len_ok = (req_len == LEN_WIDTH'(1)) || (req_len == LEN_WIDTH'(3)) ||
                       (req_len == LEN_WIDTH'(7)) || (req_len == LEN_WIDTH'(15));
  assign req_illegal = (req_size > 3'(MAX_SIZE)) || (req_burst == BURST_RSVD) ||
                       ((req_burst == BURST_WRAP) && !wrap_len_ok);

  // Next beat address; WRAP keeps the upper bits of the container and wraps the offset.
  logic [ADDR_WIDTH-1:0] beat_bytes, incr_addr, wrap_mask, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_d;
  assign beat_bytes = ADDR_WIDTH'(1) << size_q;
  assign incr_addr  = (addr_q & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;
  assign wrap_mask  = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
  assign cnt_d      = cnt_q + LEN_WIDTH'(1);

  always_comb begin
    addr_d = addr_q;
    unique case (burst_q)
      BURST_FIXED: addr_d = addr_q;
      BURST_INCR:  addr_d = incr_addr;
      default:     addr_d = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
    endcase
  end

`ifdef BRIDGE_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_wr_q    <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      id_q         <= '0;
      write_q      <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
`ifdef BRIDGE_SCHED_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            last_wr_q   <= grant_wr;
            write_q     <= grant_wr;
            id_q        <= req_id;
            addr_q      <= req_addr;
            len_q       <= req_len;
            size_q      <= req_size;
            burst_q     <= req_burst;
            cnt_q       <= '0;
            err_q       <= req_illegal;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
            wd_q        <= '0;
`endif
            if (req_illegal) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              beat_valid_q <= 1'b1;
              beat_last_q  <= (req_len == '0);
              state_q      <= ST_BEAT;
            end
          end
        end
        ST_BEAT: begin
          if (beat_done) begin
`ifdef BRIDGE_SCHED_TIMEOUT_EN
            wd_q <= '0;
`endif
            if (beat_last_q) begin
              beat_valid_q <= 1'b0;
              beat_last_q  <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_err_q   <= err_q | beat_err;
              state_q      <= ST_RESP;
            end else begin
              err_q       <= err_q | beat_err;
              addr_q      <= addr_d;
              cnt_q       <= cnt_d;
              beat_last_q <= (cnt_d == len_q);
            end
          end
`ifdef BRIDGE_SCHED_TIMEOUT_EN
          // Expiry only when no beat_done arrived this cycle.
          else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q    <= 1'b1;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign beat_valid = beat_valid_q;
  assign beat_addr  = addr_q;
  assign beat_write = write_q;
  assign beat_last  = beat_last_q;
  assign beat_id    = id_q;
  assign resp_valid = resp_valid_q;
  assign resp_write = write_q;
  assign resp_id    = id_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_bridge_xfer_sched.sv
// Self-checking bench for bridge_xfer_sched: a scoreboard of expected beats and
// responses is filled when each request is driven and drained as the DUT emits
// beats and responses.
module tb_bridge_xfer_sched;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [LW-1:0] rd_req_len;
  logic [2:0]    rd_req_size;
  logic [1:0]    rd_req_burst;
  logic [IW-1:0] rd_req_id;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [LW-1:0] wr_req_len;
  logic [2:0]    wr_req_size;
  logic [1:0]    wr_req_burst;
  logic [IW-1:0] wr_req_id;
  logic          beat_valid, beat_write, beat_last, beat_done, beat_err;
  logic [AW-1:0] beat_addr;
  logic [IW-1:0] beat_id;
  logic          resp_valid, resp_ready, resp_write, resp_err, timeout;
  logic [IW-1:0] resp_id;

  bridge_xfer_sched #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_size(rd_req_size), .rd_req_burst(rd_req_burst),
    .rd_req_id(rd_req_id),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_req_size(wr_req_size), .wr_req_burst(wr_req_burst),
    .wr_req_id(wr_req_id),
    .beat_valid(beat_valid), .beat_addr(beat_addr), .beat_write(beat_write),
    .beat_last(beat_last), .beat_id(beat_id), .beat_done(beat_done), .beat_err(beat_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_id(resp_id), .resp_err(resp_err), .timeout(timeout)
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  typedef struct {
    logic          write;
    logic [IW-1:0] id;
    logic          err;
  } resp_t;

  beat_t exp_beats[$];
  resp_t exp_resps[$];

  // Reference beat address from the AXI burst definition.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input int len,
                                               input int size, input logic [1:0] burst,
                                               input int i);
    logic [AW-1:0] b, cont, base, off;
    b = AW'(1) << size;
    case (burst)
      2'd0: return a;
      2'd1: return (i == 0) ? a : (a / b) * b + AW'(i) * b;
      default: begin
        cont = AW'(len + 1) * b;
        base = (a / cont) * cont;
        off  = (a - base + AW'(i) * b) % cont;
        return base + off;
      end
    endcase
  endfunction

  task automatic push_expect(input bit wr, input logic [AW-1:0] addr, input int len,
                             input int size, input logic [1:0] burst,
                             input logic [IW-1:0] id, input bit slv_err);
    bit    legal;
    beat_t b;
    resp_t r;
    legal = (size <= 2) && (burst != 2'd3) && (burst != 2'd2 || len inside {1, 3, 7, 15});
    if (legal) begin
      for (int i = 0; i <= len; i++) begin
        b.addr  = model_addr(addr, len, size, burst, i);
        b.write = wr;
        b.last  = (i == len);
        b.id    = id;
        exp_beats.push_back(b);
      end
    end
    r.write = wr;
    r.id    = id;
    r.err   = !legal || slv_err;
    exp_resps.push_back(r);
  endtask

  // Present a request on one side and hold it until accepted (bounded).
  task automatic drive_req(input bit wr, input logic [AW-1:0] addr, input int len,
                           input int size, input logic [1:0] burst, input logic [IW-1:0] id);
    bit got;
    got = 1'b0;
    if (wr) begin
      wr_req_addr = addr; wr_req_len = LW'(len); wr_req_size = 3'(size);
      wr_req_burst = burst; wr_req_id = id; wr_req_valid = 1'b1;
    end else begin
      rd_req_addr = addr; rd_req_len = LW'(len); rd_req_size = 3'(size);
      rd_req_burst = burst; rd_req_id = id; rd_req_valid = 1'b1;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      got = wr ? wr_req_ready : rd_req_ready;
      @(negedge clk);
    end
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL req_accept: wr=%0d never got ready", wr);
    end
  endtask

  // Act as the APB engine and response consumer, checking against the scoreboard.
  task automatic serve(input int err_beat, input int stop_after, input int hold);
    beat_t e;
    resp_t r;
    int    beat_i;
    bit    fin;
    beat_i = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (beat_valid === 1'b1) begin
        if (stop_after >= 0 && beat_i == stop_after) begin
          fin = 1'b1;
        end else begin
          repeat (hold) @(negedge clk);
          tests_run++;
          if (exp_beats.size() == 0) begin
            tests_failed++;
            $display("FAIL beat_unexpected: got addr=%h id=%h, expected no beat", beat_addr, beat_id);
          end else begin
            e = exp_beats.pop_front();
            if (beat_valid !== 1'b1 || beat_addr !== e.addr || beat_write !== e.write ||
                beat_last !== e.last || beat_id !== e.id) begin
              tests_failed++;
              $display("FAIL beat_%0d: got v=%b addr=%h wr=%b last=%b id=%h, expected addr=%h wr=%b last=%b id=%h",
                       beat_i, beat_valid, beat_addr, beat_write, beat_last, beat_id,
                       e.addr, e.write, e.last, e.id);
            end
          end
          beat_err  = (beat_i == err_beat);
          beat_done = 1'b1;
          @(negedge clk);
          beat_done = 1'b0;
          beat_err  = 1'b0;
          beat_i++;
          if (exp_beats.size() != 0) begin
            tests_run++;
            if (beat_valid !== 1'b1) begin
              tests_failed++;
              $display("FAIL beat_gap: got beat_valid=%b after beat %0d, expected 1", beat_valid, beat_i - 1);
            end
          end
        end
      end else if (resp_valid === 1'b1) begin
        tests_run++;
        if (exp_resps.size() == 0) begin
          tests_failed++;
          $display("FAIL resp_unexpected: got id=%h", resp_id);
        end else begin
          r = exp_resps.pop_front();
          if (resp_write !== r.write || resp_id !== r.id || resp_err !== r.err ||
              exp_beats.size() != 0) begin
            tests_failed++;
            $display("FAIL resp: got wr=%b id=%h err=%b (beats left %0d), expected wr=%b id=%h err=%b (beats left 0)",
                     resp_write, resp_id, resp_err, exp_beats.size(), r.write, r.id, r.err);
          end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        fin = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!fin) begin
      tests_run++;
      tests_failed++;
      $display("FAIL serve_wait: got no beat/response within bound, expected activity");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    beat_done = 1'b0; beat_err = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst_n = 1'b0;
    @(negedge clk);
    obs = {beat_valid, resp_valid, resp_err, beat_last, timeout, rd_req_ready, wr_req_ready};
    tests_run++;
    if (obs !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_active: got outputs=%b, expected 0000000", obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs = {beat_valid, resp_valid, resp_err, beat_last, timeout, rd_req_ready, wr_req_ready};
    tests_run++;
    if (obs !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got outputs=%b, expected 0000000", obs);
    end
  endtask

  task automatic test_incr_read();
    push_expect(1'b0, 32'h100, 3, 2, 2'd1, 4'h3, 1'b0);
    drive_req(1'b0, 32'h100, 3, 2, 2'd1, 4'h3);
    serve(-1, -1, 0);
  endtask

  task automatic test_wrap_write();
    push_expect(1'b1, 32'h10C, 3, 2, 2'd2, 4'hA, 1'b0);
    drive_req(1'b1, 32'h10C, 3, 2, 2'd2, 4'hA);
    serve(-1, -1, 1);
  endtask

  task automatic test_fixed_and_addr_wrap();
    push_expect(1'b0, 32'h40, 2, 1, 2'd0, 4'h7, 1'b0);
    drive_req(1'b0, 32'h40, 2, 1, 2'd0, 4'h7);
    serve(-1, -1, 0);
    push_expect(1'b1, 32'hFFFF_FFF8, 3, 2, 2'd1, 4'h2, 1'b0);
    drive_req(1'b1, 32'hFFFF_FFF8, 3, 2, 2'd1, 4'h2);
    serve(-1, -1, 0);
  endtask

  task automatic test_slverr();
    push_expect(1'b0, 32'h200, 2, 2, 2'd1, 4'h4, 1'b1);
    drive_req(1'b0, 32'h200, 2, 2, 2'd1, 4'h4);
    serve(1, -1, 0);
  endtask

  task automatic test_illegal();
    push_expect(1'b0, 32'h300, 1, 3, 2'd1, 4'h8, 1'b0);
    drive_req(1'b0, 32'h300, 1, 3, 2'd1, 4'h8);
    serve(-1, -1, 0);
    push_expect(1'b1, 32'h300, 1, 2, 2'd3, 4'h9, 1'b0);
    drive_req(1'b1, 32'h300, 1, 2, 2'd3, 4'h9);
    serve(-1, -1, 0);
    push_expect(1'b0, 32'h300, 2, 2, 2'd2, 4'hB, 1'b0);
    drive_req(1'b0, 32'h300, 2, 2, 2'd2, 4'hB);
    serve(-1, -1, 0);
  endtask

  task automatic test_ignored_strobes();
    beat_done = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    beat_done = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (beat_valid !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_strobes: got beat_valid=%b resp_valid=%b, expected 0 0", beat_valid, resp_valid);
    end
    push_expect(1'b1, 32'h80, 0, 2, 2'd1, 4'h1, 1'b0);
    drive_req(1'b1, 32'h80, 0, 2, 2'd1, 4'h1);
    serve(-1, -1, 0);
  endtask

  task automatic test_back_to_back();
    bit exp_wr;
    do_reset();
    rd_req_addr = 32'h200; rd_req_len = '0; rd_req_size = 3'd2; rd_req_burst = 2'd0; rd_req_id = 4'h1;
    wr_req_addr = 32'h300; wr_req_len = '0; wr_req_size = 3'd2; wr_req_burst = 2'd0; wr_req_id = 4'h2;
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_wr = (k % 2) == 1;
      #1;
      tests_run++;
      if ({rd_req_ready, wr_req_ready} !== (exp_wr ? 2'b01 : 2'b10)) begin
        tests_failed++;
        $display("FAIL arb_%0d: got rd_ready=%b wr_ready=%b, expected write=%0d granted",
                 k, rd_req_ready, wr_req_ready, exp_wr);
      end
      if (exp_wr) push_expect(1'b1, 32'h300, 0, 2, 2'd0, 4'h2, 1'b0);
      else        push_expect(1'b0, 32'h200, 0, 2, 2'd0, 4'h1, 1'b0);
      @(negedge clk);
      serve(-1, -1, 0);
    end
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    push_expect(1'b0, 32'h100, 3, 2, 2'd1, 4'h5, 1'b0);
    drive_req(1'b0, 32'h100, 3, 2, 2'd1, 4'h5);
    serve(-1, 2, 0);
    tests_run++;
    if (beat_valid !== 1'b1 || beat_addr !== 32'h108) begin
      tests_failed++;
      $display("FAIL mid_burst: got v=%b addr=%h, expected v=1 addr=00000108", beat_valid, beat_addr);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (beat_valid !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got beat_valid=%b resp_valid=%b, expected 0 0", beat_valid, resp_valid);
    end
    exp_beats.delete();
    exp_resps.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_expect(1'b0, 32'h500, 1, 2, 2'd1, 4'h6, 1'b0);
    drive_req(1'b0, 32'h500, 1, 2, 2'd1, 4'h6);
    serve(-1, -1, 0);
  endtask

`ifdef BRIDGE_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit seen;
    drive_req(1'b0, 32'h700, 3, 2, 2'd1, 4'hD);
    tests_run++;
    if (beat_valid !== 1'b1 || beat_addr !== 32'h700) begin
      tests_failed++;
      $display("FAIL to_first_beat: got v=%b addr=%h, expected v=1 addr=00000700", beat_valid, beat_addr);
    end
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = (timeout === 1'b1);
    end
    tests_run++;
    if (!seen || n != 16) begin
      tests_failed++;
      $display("FAIL to_pulse: got seen=%b after %0d cycles, expected pulse after 16", seen, n);
    end
    tests_run++;
    if (beat_valid !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_id !== 4'hD) begin
      tests_failed++;
      $display("FAIL to_resp: got bv=%b rv=%b err=%b id=%h, expected bv=0 rv=1 err=1 id=d",
               beat_valid, resp_valid, resp_err, resp_id);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (beat_valid !== 1'b0 || timeout !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_after: got bv=%b to=%b rv=%b, expected 0 0 0", beat_valid, timeout, resp_valid);
    end
  endtask
`else
  task automatic test_no_timeout();
    bit bad;
    bad = 1'b0;
    push_expect(1'b0, 32'h800, 0, 2, 2'd1, 4'hC, 1'b0);
    drive_req(1'b0, 32'h800, 0, 2, 2'd1, 4'hC);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (beat_valid !== 1'b1 || timeout !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL no_timeout: got beat dropped or timeout pulse, expected beat held and timeout 0");
    end
    serve(-1, -1, 0);
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    rd_req_addr = '0; rd_req_len = '0; rd_req_size = '0; rd_req_burst = '0; rd_req_id = '0;
    wr_req_addr = '0; wr_req_len = '0; wr_req_size = '0; wr_req_burst = '0; wr_req_id = '0;
    beat_done = 1'b0; beat_err = 1'b0; resp_ready = 1'b0;
    #2;
    test_reset();
    test_incr_read();
    test_wrap_write();
    test_fixed_and_addr_wrap();
    test_slverr();
    test_illegal();
    test_ignored_strobes();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef BRIDGE_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
